// File: rtl/bpu_resolve.sv
// Resolve side of the static branch predictor: queues fetch-time predictions and checks them at execute.
// Optional macro BPU_PERF_CNT_EN adds resolved-branch and mispredict counters.
module bpu_resolve #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid_i,
    input  logic [31:0] push_pc_i,
    input  logic        push_taken_i,
    input  logic [31:0] push_target_i,
    output logic        full_o,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        err_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mis_cnt_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem_r     [0:DEPTH-1];
    logic          taken_mem_r  [0:DEPTH-1];
    logic [31:0]   target_mem_r [0:DEPTH-1];
    logic [AW-1:0] rd_ptr_r, wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          redirect_r, err_r;
    logic [31:0]   redirect_addr_r;

    logic          res_fire_s, push_fire_s, mispredict_s, err_set_s;
    logic [31:0]   fix_addr_s;
    logic [AW-1:0] rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;

    function automatic logic mispredicted(input logic pred_taken, input logic [31:0] pred_target,
                                          input logic act_taken, input logic [31:0] act_target);
        return (pred_taken != act_taken) || (pred_taken && act_taken && (pred_target != act_target));
    endfunction

    assign full_o = (count_r == CW'(DEPTH));

    // Queue control: accept/pop decisions and next pointer/count state
    always_comb begin
        res_fire_s   = res_valid_i && (count_r != {CW{1'b0}});
        push_fire_s  = push_valid_i && !full_o;
        err_set_s    = (res_valid_i && (count_r == {CW{1'b0}})) || (push_valid_i && full_o);
        mispredict_s = 1'b0;
        fix_addr_s   = res_taken_i ? res_target_i : (pc_mem_r[rd_ptr_r] + 32'd4);
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (res_fire_s) begin
            mispredict_s = mispredicted(taken_mem_r[rd_ptr_r], target_mem_r[rd_ptr_r],
                                        res_taken_i, res_target_i);
        end else begin
            mispredict_s = 1'b0;
        end
        // A mispredict flushes everything younger, including a same-cycle push
        if (mispredict_s) begin
            rd_ptr_nxt_s = {AW{1'b0}};
            wr_ptr_nxt_s = {AW{1'b0}};
            count_nxt_s  = {CW{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_nxt_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (res_fire_s) begin
                rd_ptr_nxt_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (push_fire_s && !res_fire_s) begin
                count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (!push_fire_s && res_fire_s) begin
                count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                count_nxt_s = count_r;
            end
        end
    end

    // Prediction storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]     <= 32'd0;
                taken_mem_r[i]  <= 1'b0;
                target_mem_r[i] <= 32'd0;
            end
        end else if (push_fire_s && !mispredict_s) begin
            pc_mem_r[wr_ptr_r]     <= push_pc_i;
            taken_mem_r[wr_ptr_r]  <= push_taken_i;
            target_mem_r[wr_ptr_r] <= push_target_i;
        end
    end

    // Pointers, count, redirect and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r        <= {AW{1'b0}};
            wr_ptr_r        <= {AW{1'b0}};
            count_r         <= {CW{1'b0}};
            redirect_r      <= 1'b0;
            redirect_addr_r <= 32'd0;
            err_r           <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            count_r    <= count_nxt_s;
            redirect_r <= mispredict_s;
            err_r      <= err_r || err_set_s;
            if (mispredict_s) begin
                redirect_addr_r <= fix_addr_s;
            end
        end
    end

    assign redirect_o      = redirect_r;
    assign redirect_addr_o = redirect_addr_r;
    assign err_o           = err_r;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_cnt_r, mis_cnt_r;

    // Performance counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_r  <= 32'd0;
            mis_cnt_r <= 32'd0;
        end else begin
            if (res_fire_s) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (mispredict_s) begin
                mis_cnt_r <= mis_cnt_r + 32'd1;
            end
        end
    end

    assign br_cnt_o  = br_cnt_r;
    assign mis_cnt_o = mis_cnt_r;
`else
    assign br_cnt_o  = 32'd0;
    assign mis_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_bpu_resolve.sv
// Directed, table-driven bench for bpu_resolve (DEPTH=4), plus hand sequences for full, flush and reset cases.
module tb_bpu_resolve;
`ifdef BPU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid_i = 1'b0;
    logic [31:0] push_pc_i = 32'd0;
    logic        push_taken_i = 1'b0;
    logic [31:0] push_target_i = 32'd0;
    logic        full_o;
    logic        res_valid_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic [31:0] res_target_i = 32'd0;
    logic        redirect_o;
    logic [31:0] redirect_addr_o;
    logic        err_o;
    logic [31:0] br_cnt_o;
    logic [31:0] mis_cnt_o;

    int checks = 0;
    int failures = 0;

    bpu_resolve #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .push_valid_i(push_valid_i), .push_pc_i(push_pc_i),
        .push_taken_i(push_taken_i), .push_target_i(push_target_i),
        .full_o(full_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
        .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o), .err_o(err_o),
        .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        full;
        logic        red;
        logic [31:0] addr;
        logic        err;
    } vec_t;

    vec_t tbl [0:14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                         input logic rv, input logic rt, input logic [31:0] rtg);
        push_valid_i = pv; push_pc_i = pc; push_taken_i = pt; push_target_i = ptg;
        res_valid_i = rv; res_taken_i = rt; res_target_i = rtg;
        @(posedge clk);
        #1;
        push_valid_i = 1'b0;
        res_valid_i = 1'b0;
    endtask

    initial begin
        // {pv, pc, pt, ptg, rv, rt, rtg, full, red, addr, err} -- outputs just after the edge
        tbl[0]  = '{1'b1, 32'h100, 1'b1, 32'h0F0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
        tbl[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h0F0, 1'b0, 1'b0, 32'h0,   1'b0};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
        tbl[3]  = '{1'b1, 32'h200, 1'b1, 32'h1C0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
        tbl[4]  = '{1'b1, 32'h1C0, 1'b1, 32'h1E0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0};
        tbl[7]  = '{1'b1, 32'h2F0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h340, 1'b0, 1'b1, 32'h340, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h340, 1'b0};
        tbl[10] = '{1'b1, 32'h400, 1'b0, 32'h123, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h340, 1'b0};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h999, 1'b0, 1'b0, 32'h340, 1'b0};
        tbl[12] = '{1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h340, 1'b0};
        tbl[13] = '{1'b1, 32'h504, 1'b0, 32'h0,   1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 32'h340, 1'b0};
        tbl[14] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h340, 1'b0};

        #12;
        check("rst_redirect", {31'd0, redirect_o}, 32'd0);
        check("rst_addr", redirect_addr_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_full", {31'd0, full_o}, 32'd0);
        check("rst_br", br_cnt_o, 32'd0);
        check("rst_mis", mis_cnt_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].pv, tbl[i].pc, tbl[i].pt, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
            check($sformatf("v%0d_full", i), {31'd0, full_o}, {31'd0, tbl[i].full});
            check($sformatf("v%0d_redirect", i), {31'd0, redirect_o}, {31'd0, tbl[i].red});
            check($sformatf("v%0d_addr", i), redirect_addr_o, tbl[i].addr);
            check($sformatf("v%0d_err", i), {31'd0, err_o}, {31'd0, tbl[i].err});
        end
        check("tbl_br_cnt", br_cnt_o, PERF ? 32'd6 : 32'd0);
        check("tbl_mis_cnt", mis_cnt_o, PERF ? 32'd2 : 32'd0);

        // Fill to DEPTH, overflow push, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + 32'(i) * 32'h10, 1'b1, 32'h2000 + 32'(i) * 32'h10, 1'b0, 1'b0, 32'h0);
            check($sformatf("fill%0d_full", i), {31'd0, full_o}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("fill_err", {31'd0, err_o}, 32'd0);
        drive(1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("ovf_err", {31'd0, err_o}, 32'd1);
        check("ovf_full", {31'd0, full_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000 + 32'(i) * 32'h10);
            check($sformatf("drain%0d_redirect", i), {31'd0, redirect_o}, 32'd0);
            check($sformatf("drain%0d_full", i), {31'd0, full_o}, 32'd0);
        end
        check("drain_addr", redirect_addr_o, 32'h340);
        check("drain_br_cnt", br_cnt_o, PERF ? 32'd10 : 32'd0);

        // Async reset between edges with three stale not-taken entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3000 + 32'(i) * 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        #2 rst = 1'b1;
        #1;
        check("arst_err", {31'd0, err_o}, 32'd0);
        check("arst_addr", redirect_addr_o, 32'd0);
        check("arst_full", {31'd0, full_o}, 32'd0);
        check("arst_br", br_cnt_o, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h100, 1'b1, 32'h0F0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0F0);
        check("post_rst_redirect", {31'd0, redirect_o}, 32'd0);
        check("post_rst_err", {31'd0, err_o}, 32'd0);
        check("post_rst_br", br_cnt_o, PERF ? 32'd1 : 32'd0);
        check("post_rst_mis", mis_cnt_o, 32'd0);

        // Mispredict with a same-cycle push: the push is wrong-path and must vanish
        drive(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h704, 1'b1, 32'h900, 1'b1, 1'b0, 32'h0);
        check("flush_redirect", {31'd0, redirect_o}, 32'd1);
        check("flush_addr", redirect_addr_o, 32'h704);
        check("flush_err", {31'd0, err_o}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900);
        check("empty_res_err", {31'd0, err_o}, 32'd1);
        check("empty_res_redirect", {31'd0, redirect_o}, 32'd0);
        check("empty_res_addr", redirect_addr_o, 32'h704);
        check("end_br_cnt", br_cnt_o, PERF ? 32'd2 : 32'd0);
        check("end_mis_cnt", mis_cnt_o, PERF ? 32'd1 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
